// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and default sizes for the UART transmit arbiter
package uart_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_LENGTH    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUSY = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - client and transmitter handshake bundle for the UART transmit arbiter
// master: arbiter view (drives ack, tx_datain, tx_send, grant_id, busy, err)
// slave : environment view (drives req, req_data, tx_done_in)
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_LENGTH = DEF_DATA_LENGTH
) ();

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*DATA_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]             ack;
    logic [DATA_LENGTH-1:0]         tx_datain;
    logic                           tx_send;
    logic                           tx_done_in;
    logic [IDX_W-1:0]               grant_id;
    logic                           busy;
    logic                           err;

    modport master (
        input  req, req_data, tx_done_in,
        output ack, tx_datain, tx_send, grant_id, busy, err
    );

    modport slave (
        output req, req_data, tx_done_in,
        input  ack, tx_datain, tx_send, grant_id, busy, err
    );

endinterface

// File: rtl/uart_arb_rr_pick.sv
// rtl/uart_arb_rr_pick.sv - combinational round-robin picker
// req     : request levels
// last    : most recently served index (lowest priority this pass)
// gnt_idx : first set request scanning upward from last+1, wrapping
// any_req : at least one request set
module uart_arb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int cand;

    // Walk offsets from farthest to nearest so the closest requester after
    // last overwrites the others; offset NUM_REQ is last itself.
    always_comb begin
        gnt_idx = '0;
        cand    = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(last) + off) % NUM_REQ;
            if (req[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter among NUM_REQ producers
// clk1 : system clock
// rst  : asynchronous active-high reset
// bus  : uart_tx_arbiter_if.master (req/req_data/ack clients, tx_datain/tx_send/tx_done_in transmitter,
//        grant_id/busy/err status)
// Optional: UART_ARB_TIMEOUT_EN adds a per-transfer timeout of TIMEOUT_CYCLES with err pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_LENGTH    = DEF_DATA_LENGTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk1,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [DATA_LENGTH-1:0] tx_datain_q, tx_datain_d;
    logic                   tx_send_q, tx_send_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   sync1_q, sync1_d;
    logic                   done_s_q, done_s_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   any_req;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    uart_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (bus.req),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        tx_datain_d = tx_datain_q;
        tx_send_d   = tx_send_q;
        grant_id_d  = grant_id_q;
        last_d      = last_q;
        ack_d       = '0;
        sync1_d     = bus.tx_done_in;
        done_s_d    = sync1_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    tx_datain_d = bus.req_data[int'(pick_idx)*DATA_LENGTH +: DATA_LENGTH];
                    grant_id_d  = pick_idx;
                    tx_send_d   = 1'b1;
                    state_d     = ARM;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ARM: begin
                // A low done_s means the Transmitter took the byte; drop send
                // well before its next baud tick can bring it back to idle.
                if (!done_s_q) begin
                    tx_send_d = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                tx_send_d = 1'b0;
                if (done_s_q) begin
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = ACK;
                end
            end
            ACK: begin
                last_d  = grant_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Expiry overrides any completion seen in the same cycle: the
        // transfer is abandoned without an ack.
        if (state_q == ARM || state_q == BUSY) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                tx_send_d = 1'b0;
                err_d     = 1'b1;
                ack_d     = '0;
                last_d    = grant_id_q;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_datain_q <= '0;
            tx_send_q   <= 1'b0;
            grant_id_q  <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            ack_q       <= '0;
            busy_q      <= 1'b0;
            sync1_q     <= 1'b1;
            done_s_q    <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_datain_q <= tx_datain_d;
            tx_send_q   <= tx_send_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sync1_q     <= sync1_d;
            done_s_q    <= done_s_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.tx_datain = tx_datain_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DL   = 8;
    localparam int BAUD = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO  = 64;
`else
    localparam int TMO  = 4096;
`endif

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_LENGTH(DL)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .DATA_LENGTH    (DL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    int         frames     = 0;
    int         dbl        = 0;
    bit         model_en   = 1'b1;
    logic       tx_line    = 1'b1;
    logic [7:0] rx_q[$];
    int         ack_pulses = 0;
    int         err_pulses = 0;

    always @(negedge clk1) begin
        if (bus.ack != '0) ack_pulses <= ack_pulses + 1;
        if (bus.err)       err_pulses <= err_pulses + 1;
    end

    // Transmitter model: start on send while idle, 10-bit frame of BAUD cycles per bit.
    initial begin
        logic [9:0] fb;
        bit         ab;
        bus.tx_done_in = 1'b1;
        forever begin
            @(posedge clk1); #1;
            if (!rst && model_en && bus.tx_send && bus.tx_done_in) begin
                fb             = {1'b1, bus.tx_datain, 1'b0};
                frames++;
                bus.tx_done_in = 1'b0;
                ab             = 1'b0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    tx_line = fb[b];
                    for (int c = 0; c < BAUD && !ab; c++) begin
                        @(posedge clk1); #1;
                        if (rst) ab = 1'b1;
                    end
                end
                tx_line = 1'b1;
                if (bus.tx_send && !ab) dbl++;
                bus.tx_done_in = 1'b1;
            end
        end
    end

    // Serial receiver: samples mid-bit, LSB first.
    initial begin
        logic [7:0] rb;
        bit         rab;
        forever begin
            @(negedge tx_line);
            rb  = '0;
            rab = 1'b0;
            for (int c = 0; c < BAUD + BAUD / 2; c++) begin
                @(posedge clk1);
                if (rst) rab = 1'b1;
            end
            for (int b = 0; b < 8; b++) begin
                rb[b] = tx_line;
                for (int c = 0; c < BAUD; c++) begin
                    @(posedge clk1);
                    if (rst) rab = 1'b1;
                end
            end
            if (!rab) rx_q.push_back(rb);
        end
    end

    task automatic wait_ack(output logic [3:0] a, output bit ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk1); #1;
            if (bus.ack != '0) begin
                a  = bus.ack;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(input bit need_busy_state, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk1); #1;
            if (bus.busy && (!need_busy_state || !bus.tx_send)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] pop_rx();
        if (rx_q.size() == 0) return 8'hxx;
        return rx_q.pop_front();
    endfunction

    task automatic test_reset();
        checks++; if (bus.ack !== 4'b0000)     begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.tx_datain !== 8'h00) begin errors++; $display("FAIL reset_datain: got %h expected 00", bus.tx_datain); end
        checks++; if (bus.tx_send !== 1'b0)    begin errors++; $display("FAIL reset_send: got %b expected 0", bus.tx_send); end
        checks++; if (bus.grant_id !== 2'd0)   begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_single();
        logic [3:0] a;
        logic [7:0] rb;
        bit         ok;
        int         f0, a0;
        rx_q.delete();
        f0 = frames;
        a0 = ack_pulses;
        bus.req_data[7:0] = 8'hA5;
        bus.req           = 4'b0001;
        wait_ack(a, ok);
        bus.req = 4'b0000;
        checks++; if (!ok || a !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", a); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", bus.grant_id); end
        rb = pop_rx();
        checks++; if (rb !== 8'hA5) begin errors++; $display("FAIL single_serial: got %h expected a5", rb); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL single_frames: got %0d expected 1", frames - f0); end
        @(posedge clk1); #1;
        checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_after: ack %b busy %b expected 0000 0", bus.ack, bus.busy); end
        checks++; if (ack_pulses - a0 != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", ack_pulses - a0); end
    endtask

    task automatic test_round_robin();
        int         exp_o[6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] exp_b[4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        logic [3:0] a, ea;
        logic [7:0] rb;
        bit         ok;
        int         f0, a0, d0;
        rst = 1'b1;
        @(posedge clk1); #1;
        rst = 1'b0;
        rx_q.delete();
        f0 = frames;
        a0 = ack_pulses;
        d0 = dbl;
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        bus.req      = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack(a, ok);
            if (k == 5) bus.req = 4'b0000;
            ea = 4'b0001 << exp_o[k];
            checks++; if (!ok || a !== ea) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", k, a, ea); end
            rb = pop_rx();
            checks++; if (rb !== exp_b[exp_o[k]]) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, rb, exp_b[exp_o[k]]); end
            @(posedge clk1); #1;
            checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL rr_gap_%0d: busy %b ack %b expected 0 0000", k, bus.busy, bus.ack); end
        end
        checks++; if (frames - f0 != 6) begin errors++; $display("FAIL rr_frames: got %0d expected 6", frames - f0); end
        checks++; if (ack_pulses - a0 != 6) begin errors++; $display("FAIL rr_ack_count: got %0d expected 6", ack_pulses - a0); end
        checks++; if (dbl != d0) begin errors++; $display("FAIL rr_double_send: got %0d expected %0d", dbl, d0); end
    endtask

    task automatic test_drop_after_grant();
        logic [3:0] a;
        logic [7:0] rb;
        bit         ok;
        rx_q.delete();
        bus.req_data[23:16] = 8'h3C;
        bus.req             = 4'b0100;
        wait_grant(1'b0, ok);
        bus.req             = 4'b0000;
        bus.req_data[23:16] = 8'h00;
        checks++; if (!ok || bus.grant_id !== 2'd2 || bus.tx_send !== 1'b1) begin errors++; $display("FAIL drop_grant: ok %b grant %0d send %b expected 1 2 1", ok, bus.grant_id, bus.tx_send); end
        wait_ack(a, ok);
        checks++; if (!ok || a !== 4'b0100) begin errors++; $display("FAIL drop_ack: got %b expected 0100", a); end
        checks++; if (bus.tx_datain !== 8'h3C) begin errors++; $display("FAIL drop_datain: got %h expected 3c", bus.tx_datain); end
        rb = pop_rx();
        checks++; if (rb !== 8'h3C) begin errors++; $display("FAIL drop_serial: got %h expected 3c", rb); end
    endtask

    task automatic test_rst_mid();
        logic [3:0] a;
        logic [7:0] rb;
        bit         ok;
        int         a0;
        bus.req_data[7:0] = 8'h77;
        bus.req           = 4'b0001;
        wait_grant(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_busy: got timeout expected busy state"); end
        a0  = ack_pulses;
        rst = 1'b1;
        @(posedge clk1); #1;
        checks++; if (bus.busy !== 1'b0 || bus.tx_send !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: busy %b send %b expected 0 0", bus.busy, bus.tx_send); end
        checks++; if (bus.grant_id !== 2'd0 || bus.tx_datain !== 8'h00) begin errors++; $display("FAIL rstmid_regs: grant %0d datain %h expected 0 00", bus.grant_id, bus.tx_datain); end
        bus.req = 4'b0000;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        repeat (50) @(posedge clk1);
        #1;
        checks++; if (ack_pulses != a0) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ack_pulses - a0); end
        rx_q.delete();
        bus.req_data[31:24] = 8'h5A;
        bus.req             = 4'b1000;
        wait_grant(1'b0, ok);
        checks++; if (!ok || bus.grant_id !== 2'd3) begin errors++; $display("FAIL rstmid_regrant: got %0d expected 3", bus.grant_id); end
        wait_ack(a, ok);
        bus.req = 4'b0000;
        checks++; if (!ok || a !== 4'b1000) begin errors++; $display("FAIL rstmid_ack: got %b expected 1000", a); end
        rb = pop_rx();
        checks++; if (rb !== 8'h5A) begin errors++; $display("FAIL rstmid_serial: got %h expected 5a", rb); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] a;
        logic [7:0] rb;
        bit         ok;
        rx_q.delete();
        bus.req_data = {8'hC3, 8'h00, 8'h11, 8'h00};
        bus.req      = 4'b0010;
        wait_ack(a, ok);
        bus.req = 4'b1010;
        checks++; if (!ok || a !== 4'b0010) begin errors++; $display("FAIL simul_setup: got %b expected 0010", a); end
        wait_ack(a, ok);
        checks++; if (!ok || a !== 4'b1000) begin errors++; $display("FAIL simul_first: got %b expected 1000", a); end
        wait_ack(a, ok);
        bus.req = 4'b0000;
        checks++; if (!ok || a !== 4'b0010) begin errors++; $display("FAIL simul_second: got %b expected 0010", a); end
        rb = pop_rx();
        rb = pop_rx();
        checks++; if (rb !== 8'hC3) begin errors++; $display("FAIL simul_data3: got %h expected c3", rb); end
        rb = pop_rx();
        checks++; if (rb !== 8'h11) begin errors++; $display("FAIL simul_data1: got %h expected 11", rb); end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] a;
        bit         ok;
        int         n, a0;
        repeat (5) @(posedge clk1);
        #1;
        model_en = 1'b0;
        a0       = ack_pulses;
        bus.req  = 4'b0001;
        wait_grant(1'b0, ok);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk1); #1;
            if (bus.err) begin
                n = i;
                break;
            end
        end
        bus.req = 4'b0011;
        checks++; if (n != 64) begin errors++; $display("FAIL tmo_cycle: got %0d expected 64", n); end
        checks++; if (bus.tx_send !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL tmo_outputs: send %b ack %b expected 0 0000", bus.tx_send, bus.ack); end
        model_en = 1'b1;
        wait_grant(1'b0, ok);
        checks++; if (!ok || bus.grant_id !== 2'd1) begin errors++; $display("FAIL tmo_next: got %0d expected 1", bus.grant_id); end
        wait_ack(a, ok);
        bus.req = 4'b0000;
        checks++; if (!ok || a !== 4'b0010) begin errors++; $display("FAIL tmo_next_ack: got %b expected 0010", a); end
        checks++; if (ack_pulses - a0 != 1 || err_pulses != 1) begin errors++; $display("FAIL tmo_counts: acks %0d errs %0d expected 1 1", ack_pulses - a0, err_pulses); end
    endtask
`else
    task automatic test_no_err();
        checks++; if (err_pulses != 0 || bus.err !== 1'b0) begin errors++; $display("FAIL err_tied: pulses %0d err %b expected 0 0", err_pulses, bus.err); end
    endtask
`endif

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(posedge clk1);
        #1;
        test_reset();
        rst = 1'b0;
        test_single();
        test_round_robin();
        test_drop_after_grant();
        test_rst_mid();
        test_simultaneous();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Sits between client logic and the Transmitter. Drives the Transmitter's datain/send and watches its tx_done.
- Runs on the fast system clock clk1. The Transmitter runs on its own baud-rate enable, so the arbiter hand-shakes across that rate difference.
- Issues exactly one send per granted byte and acks the requester when the frame has finished.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_LENGTH, 8, byte width; must match the Transmitter's Data_length.
- TIMEOUT_CYCLES, 4096, clk1 cycles allowed per transfer (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk1  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*DATA_LENGTH  packed bytes; requester i uses slice [i*DATA_LENGTH +: DATA_LENGTH].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i fully transmitted.
- tx_datain  out  DATA_LENGTH  byte presented to the Transmitter.
- tx_send  out  1  send request to the Transmitter.
- tx_done_in  in  1  Transmitter's tx_done; high means idle.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset values: ack=0, tx_datain=0, tx_send=0, grant_id=0, busy=0, err=0, state=IDLE. RR pointer last=NUM_REQ-1, so req[0] wins first.
- tx_done_in passes through a 2-flop synchronizer (reset to 1) giving done_s. All decisions use done_s.
- IDLE:
  - If |req: pick the first set req scanning from last+1 upward, wrapping modulo NUM_REQ.
  - Latch its slice into tx_datain, set grant_id, go to ARM.
  - No request: stay in IDLE.
- ARM:
  - tx_send=1.
  - When done_s==0 (Transmitter has started): tx_send<=0, go to BUSY.
  - tx_send must drop before the Transmitter's next baud tick returns it to idle, so there is never a double send.
- BUSY: tx_send=0. When done_s==1: go to ACK.
- ACK: ack[grant_id]=1 for exactly one cycle, last<=grant_id, go to IDLE. Back-to-back grants are therefore at least 1 idle cycle apart.
- Minimum latency: grant to ack = 3 clk1 cycles + synchronizer delay + full frame time.
- Data is captured at grant. The requester may change req_data or drop req after grant; the transfer completes and ack still pulses.
- A requester holding req after its ack is re-arbitrated normally and gets lowest priority next round.
- Simultaneous requests: exactly one grant per IDLE pass. Fairness: every continuously asserted requester is served within NUM_REQ transfers.
- tx_datain holds its value from grant until the next grant; it is not cleared in IDLE.
- rst mid-transfer: all state returns to reset values immediately and no ack is issued. The Transmitter shares rst, so it also aborts.
- done_s already low on entry to ARM (Transmitter busy from a foreign source): treated as started, so the frame is not retransmitted. This is not a supported use.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ARM and increments each cycle in ARM and BUSY.
  - On reaching TIMEOUT_CYCLES-1: tx_send<=0, err pulses for 1 cycle, no ack, last<=grant_id, state goes to IDLE.
- Without the macro: no counter, err is a constant 0, and ARM/BUSY wait indefinitely.

Decomposition:
- Package uart_arb_pkg holds the state enum (IDLE, ARM, BUSY, ACK; 2-bit encoding) and the default localparams.
- One sub-module, uart_arb_rr_pick: combinational round-robin picker. Inputs req and last; outputs gnt_idx and any_req.
- Synchronizer, FSM and timeout stay in the top module.

Test Plan:
- Single request: req=4'b0001, data 0xA5 → tx_send rises, falls after tx_done_in falls, then ack=4'b0001 once after tx_done_in rises; the Transmitter serial line carries 0xA5 LSB first.
- All four requesting continuously from reset: grant order 0,1,2,3,0,1; exactly one ack per frame; no second tx_send pulse within a frame.
- req[2] dropped and req_data[2] changed to 0x00 one cycle after grant with 0x3C latched → 0x3C is transmitted and ack[2] still pulses.
- rst asserted while in BUSY → outputs return to reset values next edge; no ack; after release req=4'b1000 is granted with grant_id=3.
- Requests 1 and 3 set simultaneously with last=1 → 3 is granted first, then 1.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, tx_done_in stuck high → err pulses at cycle 64 after ARM entry, tx_send low, no ack, next requester granted.
